// File: rtl/seq_sorter_pkg.sv
// Shared types and helpers for the sequential odd-even transposition sorter.
package sorter_pkg;

    localparam int DEF_N = 8;
    localparam int DEF_W = 8;
    localparam int MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE,
        SORT,
        DONE
    } state_t;

    // Flipping the sign bit maps two's complement order onto unsigned order.
    function automatic logic sorter_gt(input logic [MAX_W-1:0] a,
                                       input logic [MAX_W-1:0] b,
                                       input int               w,
                                       input logic             is_signed);
        logic [MAX_W-1:0] flip;
        flip = is_signed ? (MAX_W'(1) << (w - 1)) : '0;
        return (a ^ flip) > (b ^ flip);
    endfunction

endpackage

// File: rtl/seq_sorter_if.sv
// Input/output handshake bundle of the sequential sorter.
interface seq_sorter_if
    import sorter_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int W = DEF_W
);
    logic           in_valid;
    logic           in_ready;
    logic [N*W-1:0] in_data;
    logic           in_desc;
    logic           out_valid;
    logic           out_ready;
    logic [N*W-1:0] out_data;
    logic           busy;

    modport master (
        output in_valid, in_data, in_desc, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, in_desc, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/seq_sorter_cmp_swap.sv
// Single compare-exchange cell: lo_out feeds the lower element index.
module cmp_swap
    import sorter_pkg::*;
#(
    parameter int W      = DEF_W,
    parameter int SIGNED = 0
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         desc,
    output logic [W-1:0] lo_out,
    output logic [W-1:0] hi_out
);
    logic a_gt_b;
    logic b_gt_a;
    logic swap;

    assign a_gt_b = sorter_gt(MAX_W'(a), MAX_W'(b), W, SIGNED != 0);
    assign b_gt_a = sorter_gt(MAX_W'(b), MAX_W'(a), W, SIGNED != 0);

    // Strict compares in both directions keep equal elements in place.
    assign swap   = desc ? b_gt_a : a_gt_b;
    assign lo_out = swap ? b : a;
    assign hi_out = swap ? a : b;
endmodule

// File: rtl/seq_sorter.sv
// Sequential sorter: loads a vector, runs N odd-even transposition passes, presents result.
module seq_sorter
    import sorter_pkg::*;
#(
    parameter int N      = DEF_N,
    parameter int W      = DEF_W,
    parameter int SIGNED = 0
) (
    input logic         clk,
    input logic         rst_n,
    seq_sorter_if.slave bus
);
    localparam int PW = $clog2(N + 1);
    localparam int NE = N / 2;
    localparam int NO = (N - 1) / 2;

    state_t          state_reg, state_next;
    logic [PW-1:0]   p_reg, p_next;
    logic            desc_reg;
    logic [W-1:0]    elem_reg  [N];
    logic [W-1:0]    pass_even [N];
    logic [W-1:0]    pass_odd  [N];
    logic            load;
    logic            last_pass;

    assign load      = (state_reg == IDLE) && bus.in_valid;
    assign last_pass = (p_reg == PW'(N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            p_reg     <= '0;
            desc_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            p_reg     <= p_next;
            if (load) begin
                desc_reg <= bus.in_desc;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        p_next     = p_reg;
        case (state_reg)
            IDLE: begin
                if (bus.in_valid) begin
                    // A single element is already sorted, so skip straight to DONE.
                    state_next = (N == 1) ? DONE : SORT;
                    p_next     = '0;
                end
            end
            SORT: begin
                if (last_pass) begin
                    state_next = DONE;
                end
                p_next = (p_reg == PW'(N)) ? p_reg : p_reg + PW'(1);
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = (state_reg == DONE);
    assign bus.busy      = (state_reg == SORT);

    // Even pass: pairs (0,1), (2,3), ...
    for (genvar gi = 0; gi < NE; gi++) begin : g_even
        cmp_swap #(.W(W), .SIGNED(SIGNED)) u_cell (
            .a      (elem_reg[2*gi]),
            .b      (elem_reg[2*gi+1]),
            .desc   (desc_reg),
            .lo_out (pass_even[2*gi]),
            .hi_out (pass_even[2*gi+1])
        );
    end

    // Odd pass: pairs (1,2), (3,4), ...
    for (genvar gi = 0; gi < NO; gi++) begin : g_odd
        cmp_swap #(.W(W), .SIGNED(SIGNED)) u_cell (
            .a      (elem_reg[2*gi+1]),
            .b      (elem_reg[2*gi+2]),
            .desc   (desc_reg),
            .lo_out (pass_odd[2*gi+1]),
            .hi_out (pass_odd[2*gi+2])
        );
    end

    assign pass_odd[0] = elem_reg[0];

    if (N % 2 == 1) begin : g_even_tail
        assign pass_even[N-1] = elem_reg[N-1];
    end

    if (N % 2 == 0) begin : g_odd_tail
        assign pass_odd[N-1] = elem_reg[N-1];
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_elem
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                elem_reg[gi] <= '0;
            end else if (load) begin
                elem_reg[gi] <= bus.in_data[gi*W +: W];
            end else if (state_reg == SORT) begin
                elem_reg[gi] <= p_reg[0] ? pass_odd[gi] : pass_even[gi];
            end
        end

        assign bus.out_data[gi*W +: W] = elem_reg[gi];
    end
endmodule

// File: tb/tb_seq_sorter.sv
// Self-checking bench for seq_sorter: cycle-level monitor against a sort model plus directed vectors.
module tb_seq_sorter;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] IN_A   = 64'h0406020701080305;
    localparam logic [63:0] ASC_A  = 64'h0807060504030201;
    localparam logic [63:0] DESC_A = 64'h0102030405060708;
    localparam logic [63:0] IN_REV = 64'h0102030405060708;
    localparam logic [63:0] IN_DUP = 64'h03FF0003FF000303;
    localparam logic [63:0] SRT_DUP = 64'hFFFF030303030000;
    localparam logic [63:0] IN_S   = 64'h4030201000FF7F80;
    localparam logic [63:0] SRT_S  = 64'h7F4030201000FF80;
    localparam logic [63:0] SRT_U  = 64'hFF807F4030201000;

    always #5 clk = ~clk;

    seq_sorter_if #(.N(8), .W(8)) b0 ();
    seq_sorter_if #(.N(8), .W(8)) b1 ();
    seq_sorter_if #(.N(1), .W(8)) b2 ();

    seq_sorter #(.N(8), .W(8), .SIGNED(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    seq_sorter #(.N(8), .W(8), .SIGNED(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    seq_sorter #(.N(1), .W(8), .SIGNED(0)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: a plain full sort of the eight byte values.
    function automatic logic [63:0] model_sort(input logic [63:0] d, input logic desc, input bit sgn);
        int         v[8];
        int         t;
        logic [7:0] b;
        logic [63:0] r;
        for (int i = 0; i < 8; i++) begin
            b    = d[i*8 +: 8];
            v[i] = sgn ? int'($signed(b)) : int'(b);
        end
        for (int i = 0; i < 8; i++) begin
            for (int j = i + 1; j < 8; j++) begin
                if (desc ? (v[j] > v[i]) : (v[j] < v[i])) begin
                    t = v[i]; v[i] = v[j]; v[j] = t;
                end
            end
        end
        r = '0;
        for (int i = 0; i < 8; i++) r[i*8 +: 8] = 8'(v[i]);
        return r;
    endfunction

    // Cycle monitor for u0: 0 = waiting for input, 1 = sorting, 2 = result held.
    int          m_st   = 0;
    int          m_left = 0;
    logic [63:0] m_res  = '0;

    always @(negedge clk) begin
        if (!rst_n) m_st = 0;
        chk("mon_in_ready", 64'(b0.in_ready), 64'(m_st == 0));
        chk("mon_out_valid", 64'(b0.out_valid), 64'(m_st == 2));
        chk("mon_busy", 64'(b0.busy), 64'(m_st == 1));
        if (m_st == 2) chk("mon_out_data", b0.out_data, m_res);
        if (!rst_n) chk("mon_rst_data", b0.out_data, 64'h0);
        if (rst_n) begin
            if (m_st == 0) begin
                if (b0.in_valid) begin
                    m_res  = model_sort(b0.in_data, b0.in_desc, 1'b0);
                    m_left = 8;
                    m_st   = 1;
                end
            end else if (m_st == 1) begin
                m_left--;
                if (m_left == 0) m_st = 2;
            end else if (b0.out_ready) begin
                m_st = 0;
            end
        end
    end

    task automatic xfer0(input logic [63:0] d, input logic dsc, input int hold, output logic [63:0] got);
        int n;
        n = 0;
        while (!b0.in_ready && n < 50) begin @(posedge clk); #1; n++; end
        chk("wait_in_ready", 64'(n >= 50), 64'h0);
        b0.in_data  = d;
        b0.in_desc  = dsc;
        b0.in_valid = 1'b1;
        @(posedge clk); #1;
        n = 0;
        while (!b0.out_valid && n < 50) begin
            b0.in_valid = 1'($urandom_range(0, 1));
            b0.in_data  = {$urandom, $urandom};
            b0.in_desc  = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            n++;
        end
        chk("wait_out_valid", 64'(n >= 50), 64'h0);
        for (int i = 0; i < hold; i++) begin
            b0.in_valid = 1'($urandom_range(0, 1));
            b0.in_data  = {$urandom, $urandom};
            @(posedge clk); #1;
        end
        got          = b0.out_data;
        b0.in_valid  = 1'b0;
        b0.out_ready = 1'b1;
        @(posedge clk); #1;
        b0.out_ready = 1'b0;
        $display("xfer in=%h desc=%0d hold=%0d out=%h", d, dsc, hold, got);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] got;
        logic [63:0] d;
        logic [7:0]  s;
        int          n;

        b0.in_valid = 0; b0.in_data = '0; b0.in_desc = 0; b0.out_ready = 0;
        b1.in_valid = 0; b1.in_data = '0; b1.in_desc = 0; b1.out_ready = 0;
        b2.in_valid = 0; b2.in_data = '0; b2.in_desc = 0; b2.out_ready = 0;

        #2;
        chk("rst_in_ready", 64'(b0.in_ready), 64'h1);
        chk("rst_out_valid", 64'(b0.out_valid), 64'h0);
        chk("rst_busy", 64'(b0.busy), 64'h0);
        chk("rst_out_data", b0.out_data, 64'h0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        chk("pin_model_asc", model_sort(IN_A, 1'b0, 1'b0), ASC_A);
        chk("pin_model_dup", model_sort(IN_DUP, 1'b0, 1'b0), SRT_DUP);
        chk("pin_model_signed", model_sort(IN_S, 1'b0, 1'b1), SRT_S);

        xfer0(IN_A, 1'b0, 0, got);   chk("asc", got, ASC_A);
        xfer0(IN_A, 1'b1, 0, got);   chk("desc", got, DESC_A);
        xfer0(IN_REV, 1'b0, 0, got); chk("reverse", got, ASC_A);
        xfer0(IN_DUP, 1'b0, 1, got); chk("dups", got, SRT_DUP);
        xfer0(IN_S, 1'b0, 2, got);   chk("unsigned_cmp", got, SRT_U);
        xfer0(IN_A, 1'b0, 20, got);  chk("backpressure", got, ASC_A);

        // Abort a vector while pass 3 is pending.
        b0.in_data = IN_A; b0.in_desc = 1'b0; b0.in_valid = 1'b1;
        @(posedge clk); #1;
        b0.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 64'(b0.out_valid), 64'h0);
        chk("abort_in_ready", 64'(b0.in_ready), 64'h1);
        chk("abort_busy", 64'(b0.busy), 64'h0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        xfer0(IN_REV, 1'b1, 0, got); chk("after_abort", got, DESC_A);

        for (int k = 0; k < 40; k++) begin
            d = '0;
            for (int i = 0; i < 8; i++) begin
                s = (k % 3 == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
                d[i*8 +: 8] = s;
            end
            xfer0(d, 1'($urandom_range(0, 1)), $urandom_range(0, 3), got);
        end

        // Signed configuration.
        for (int k = 0; k < 2; k++) begin
            b1.in_data = IN_S; b1.in_desc = 1'(k); b1.in_valid = 1'b1;
            @(posedge clk); #1;
            b1.in_valid = 1'b0;
            n = 0;
            while (!b1.out_valid && n < 20) begin @(posedge clk); #1; n++; end
            chk("signed_latency", 64'(n), 64'd8);
            chk("signed_data", b1.out_data, model_sort(IN_S, 1'(k), 1'b1));
            if (k == 0) chk("signed_literal", b1.out_data, SRT_S);
            $display("xfer signed in=%h desc=%0d out=%h", IN_S, k, b1.out_data);
            b1.out_ready = 1'b1;
            @(posedge clk); #1;
            b1.out_ready = 1'b0;
        end

        // Single-element configuration.
        for (int k = 0; k < 5; k++) begin
            s = 8'($urandom);
            b2.in_data = s; b2.in_desc = 1'($urandom_range(0, 1)); b2.in_valid = 1'b1;
            @(posedge clk); #1;
            b2.in_valid = 1'b0;
            chk("n1_out_valid", 64'(b2.out_valid), 64'h1);
            chk("n1_busy", 64'(b2.busy), 64'h0);
            chk("n1_data", 64'(b2.out_data), 64'(s));
            $display("xfer n1 in=%h out=%h", s, b2.out_data);
            b2.out_ready = 1'b1;
            @(posedge clk); #1;
            b2.out_ready = 1'b0;
            chk("n1_in_ready", 64'(b2.in_ready), 64'h1);
        end

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_sorter.md
# seq_sorter

Parametrised, clocked successor to the combinational 8×8-bit sorter. It accepts a vector of N elements of W bits each over a valid/ready handshake, then sorts the vector in place using odd-even transposition, one compare-exchange pass per clock. It presents the sorted vector over a second valid/ready handshake. Compared with the combinational sorter, it adds:

- runtime ascending/descending selection;
- signed/unsigned compare;
- back-pressure on both sides.

## Interface
Parameters:
- N, 8, number of elements; must be ≥1.
- W, 8, element width in bits.
- SIGNED, 0, 1 = compare as two's complement, 0 = unsigned.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input vector is valid.
- in_ready  out  1  block can accept a vector.
- in_data  in  N*W  element i at bits [i*W +: W].
- in_desc  in  1  sort order; 0 = ascending, 1 = descending. Sampled with in_data.
- out_valid  out  1  sorted vector available.
- out_ready  in  1  consumer accepts the vector.
- out_data  out  N*W  sorted vector; same element packing as in_data.
- busy  out  1  high in SORT state.

## Operation
- States:
  - IDLE: in_ready=1.
  - SORT: pass counter p runs from 0 to N-1.
  - DONE: out_valid=1.
- IDLE → SORT on in_valid && in_ready. On that edge:
  - in_data loads into the element registers;
  - in_desc is latched;
  - p=0.
  - If N=1, the block goes IDLE → DONE directly.
- Each edge in SORT performs pass p on the element registers:
  - p even: compare-exchange pairs (0,1), (2,3), …
  - p odd: compare-exchange pairs (1,2), (3,4), …
  - Unpaired end elements hold.
- Compare-exchange rule:
  - Ascending: swap iff e[i] > e[i+1].
  - Descending: swap iff e[i] < e[i+1].
  - Equal elements never swap.
  - Compare is signed or unsigned per SIGNED.
- SORT → DONE on the edge that executes pass p=N-1.
- DONE → IDLE on out_valid && out_ready.
- out_data always reflects the element registers:
  - it is stable throughout DONE;
  - its value outside DONE is don't-care for the consumer.
- Input while not IDLE: in_data/in_desc are ignored and in_ready=0. No overlap of successive vectors.
- Output result:
  - ascending ⇒ element 0 is the minimum and element N-1 the maximum;
  - descending ⇒ the reverse.

## Timing
- Reset values (asynchronous, immediate on rst_n low):
  - state=IDLE, in_ready=1, out_valid=0, busy=0;
  - p=0, element registers=0, latched desc=0.
- Reset mid-SORT or mid-DONE aborts the vector. The block returns to IDLE; no output is produced.
- Latency: if the vector is accepted at edge t, out_valid rises after edge t+N. For N=1, out_valid rises after edge t.
- out_valid holds until the handshake, regardless of how many cycles out_ready stays low.
- in_ready rises the cycle after the output handshake. Peak throughput is one vector per N+2 cycles.
- out_valid, in_ready and busy are registered (state-decoded). There are no combinational in→out paths.
- Counter width is $clog2(N+1). The counter saturates and does not wrap; it is cleared on every load.

## Structure
- Package sorter_pkg holds:
  - state enum {IDLE, SORT, DONE};
  - default N/W localparams;
  - a function for the signed/unsigned greater-than on W bits.
- Sub-module cmp_swap (parameters W, SIGNED): combinational, taking inputs a, b, desc and producing lo_out, hi_out per the compare-exchange rule.
- Top instantiates N/2 cells for even passes and (N-1)/2 cells for odd passes, muxed by p[0].

## Test plan
- Ascending, N=8, W=8, in {5,3,8,1,7,2,6,4} (element 0 first) → out {1,2,3,4,5,6,7,8}; out_valid rises 8 cycles after acceptance.
- Descending, same input, in_desc=1 → {8,7,6,5,4,3,2,1}.
- Worst case and duplicates:
  - in {8,7,…,1}, ascending → sorted in exactly 8 passes;
  - in {3,3,0,255,3,0,255,3} → {0,0,3,3,3,3,255,255}.
- SIGNED=1, in {0x80,0x7F,0xFF,0x00,…} → 0x80 (−128) is first and 0x7F last. The same input with SIGNED=0 puts 0x00 first.
- Back-pressure:
  - out_ready held low 20 cycles → out_valid and out_data stable, in_ready=0;
  - in_valid pulses during SORT are ignored;
  - handshake → in_ready=1 the next cycle.
- rst_n pulled low mid-SORT (pass 3) → immediately out_valid=0 and in_ready=1. A subsequent vector sorts correctly. N=1 configuration: out equals in, one cycle later.
